debounce_sync: RTL

Input conditioning stage that sits directly upstream of the team's D flip-flop cells (DF1/DFR1/DFSR1). It feeds their `d` input with a clean, clock-synchronous level. An asynchronous, possibly bouncing input (push-button, external strobe) first passes through a multi-flop synchronizer. A four-state debounce FSM then accepts a new level only after it has been stable for a programmable number of cycles, and emits single-cycle rise/fall pulses on each accepted change.

---
 rtl/debounce_sync.sv | 120 ++++++++++++
 1 files changed

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw async input; dout/rise/fall follow SYNC_STAGES+STABLE_CYCLES edges after a stable change.
// Free-running conditioning stage with no handshake: every output is registered and updates on each clk edge.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 10,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        CHK_H = 2'd1,
        HIGH  = 2'd2,
        CHK_L = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s     = sync_q[SYNC_STAGES-1];
    assign cnt_d = cnt_q + CNT_ONE;

    // cnt holds the number of consecutive samples already seen at the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                LOW: begin
                    if (s) begin
                        state_q <= CHK_H;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                CHK_H: begin
                    if (!s) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_TERM) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        dout_q  <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_q <= CHK_L;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                CHK_L: begin
                    if (s) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_TERM) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        dout_q  <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                    dout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule
